// File: rtl/smult_mac_acc.sv
// Signed multiply-accumulate stage: sums a frame of signed products into a wider
// accumulator with optional saturation. Emits one result per frame over valid/ready.
module smult_mac_acc #(
  parameter int PROD_W    = 16,
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 16,
  parameter int SATURATE  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [PROD_W-1:0]             prod,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [ACC_W-1:0]              acc_out,
  output logic [$clog2(MAX_TERMS+1)-1:0]       out_count,
  output logic                                 ovf
);

  localparam int CW = $clog2(MAX_TERMS+1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TERMS);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CW-1:0]           count;
  logic                    ovf_q;

  logic                    accept;
  logic [ACC_W:0]          sum;
  logic                    sum_ovf;
  logic [ACC_W-1:0]        acc_next;
  logic [CW-1:0]           count_inc;
  logic                    close;

  // Sum at ACC_W+1 bits; the top two bits disagreeing means the result left the ACC_W range.
  always_comb begin
    accept    = in_valid && in_ready;
    sum       = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    sum_ovf   = sum[ACC_W] ^ sum[ACC_W-1];
    acc_next  = sum[ACC_W-1:0];
    if (sum_ovf && (SATURATE != 0)) begin
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    count_inc = count + 1'b1;
    close     = in_last || (count_inc == MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= acc_next;
            count <= count_inc;
            if (sum_ovf) ovf_q <= 1'b1;
            if (close) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            ovf_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    acc_out   = acc;
    out_count = count;
    ovf       = ovf_q;
  end

endmodule
